bp_update_scheduler: RTL and testbench

//  Serialises branch-predictor training onto one pattern-table port, behind the lookup path.

---
 rtl/bp_update_scheduler.sv | 161 ++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// Branch-predictor training scheduler: serialises outcome updates (queued RMW) and
// rollback restores onto one pattern-table port, sweeping the table after reset.
module bp_update_scheduler #(
  parameter int unsigned          IDX_WIDTH   = 10,
  parameter int unsigned          CNT_WIDTH   = 2,
  parameter logic [CNT_WIDTH-1:0] INIT_VALUE  = '0,
  parameter int unsigned          QDEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PL_stall,
  input  logic                   upd_valid,
  input  logic [IDX_WIDTH-1:0]   upd_idx,
  input  logic                   upd_taken,
  output logic                   upd_ready,
  input  logic                   rb_valid,
  input  logic [IDX_WIDTH-1:0]   rb_idx,
  input  logic [CNT_WIDTH-1:0]   rb_count,
  input  logic                   tbl_gnt,
  output logic                   tbl_re,
  output logic [IDX_WIDTH-1:0]   tbl_raddr,
  input  logic [CNT_WIDTH-1:0]   tbl_rdata,
  output logic                   tbl_we,
  output logic [IDX_WIDTH-1:0]   tbl_waddr,
  output logic [CNT_WIDTH-1:0]   tbl_wdata,
  output logic                   init_busy,
  output logic [QDEPTH_LOG2:0]   q_count
);

  localparam int unsigned DEPTH = 2 ** QDEPTH_LOG2;
  localparam int unsigned CW    = QDEPTH_LOG2 + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    logic                 taken;
  } upd_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   sweep_q, sweep_d;
  upd_t                   fifo_q [DEPTH];
  logic [QDEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   w_valid_q, w_valid_d, w_taken_q, w_taken_d;
  logic [IDX_WIDTH-1:0]   w_idx_q, w_idx_d;
  logic                   fwd_valid_q, fwd_valid_d;
  logic [IDX_WIDTH-1:0]   fwd_idx_q, fwd_idx_d;
  logic [CNT_WIDTH-1:0]   fwd_data_q, fwd_data_d;
  logic                   push, pop;
  logic [CNT_WIDTH-1:0]   w_base, w_new;
  upd_t                   head;

  assign head      = fifo_q[rd_ptr_q];
  assign init_busy = (state_q == S_INIT);
  assign q_count   = count_q;
  assign upd_ready = !rst && (state_q == S_RUN) && (count_q != CW'(DEPTH)) && !rb_valid;

  // A read issued in the same cycle as a W write sees the stale value, so forward it
  assign w_base = (fwd_valid_q && (fwd_idx_q == w_idx_q)) ? fwd_data_q : tbl_rdata;
  assign w_new  = w_taken_q ? ((w_base == '1) ? w_base : w_base + CNT_WIDTH'(1))
                            : ((w_base == '0) ? w_base : w_base - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    w_valid_d   = 1'b0;
    w_idx_d     = w_idx_q;
    w_taken_d   = w_taken_q;
    fwd_valid_d = 1'b0;
    fwd_idx_d   = fwd_idx_q;
    fwd_data_d  = fwd_data_q;
    push        = 1'b0;
    pop         = 1'b0;
    tbl_re      = 1'b0;
    tbl_raddr   = '0;
    tbl_we      = 1'b0;
    tbl_waddr   = '0;
    tbl_wdata   = '0;
    if (!rst) begin
      unique case (state_q)
        S_INIT: begin
          tbl_we    = 1'b1;
          tbl_waddr = sweep_q;
          tbl_wdata = INIT_VALUE;
          sweep_d   = sweep_q + IDX_WIDTH'(1);
          if (sweep_q == '1) state_d = S_RUN;
        end
        S_RUN: begin
          push = upd_valid && upd_ready && !PL_stall;
          if (rb_valid) begin
            // Flush: restore wins the port and discards everything in flight
            tbl_we    = 1'b1;
            tbl_waddr = rb_idx;
            tbl_wdata = rb_count;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
          end else begin
            if (w_valid_q) begin
              tbl_we      = 1'b1;
              tbl_waddr   = w_idx_q;
              tbl_wdata   = w_new;
              fwd_valid_d = 1'b1;
              fwd_idx_d   = w_idx_q;
              fwd_data_d  = w_new;
            end
            pop = (count_q != '0) && tbl_gnt;
            if (pop) begin
              tbl_re    = 1'b1;
              tbl_raddr = head.idx;
              w_valid_d = 1'b1;
              w_idx_d   = head.idx;
              w_taken_d = head.taken;
              rd_ptr_d  = rd_ptr_q + QDEPTH_LOG2'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + QDEPTH_LOG2'(1);
            count_d = count_q + CW'(push) - CW'(pop);
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      w_valid_q   <= 1'b0;
      w_idx_q     <= '0;
      w_taken_q   <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_idx_q   <= '0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      w_valid_q   <= w_valid_d;
      w_idx_q     <= w_idx_d;
      w_taken_q   <= w_taken_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_idx_q   <= fwd_idx_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{idx: upd_idx, taken: upd_taken};
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: expected table writes are queued by the
// stimulus and matched by a negedge monitor against a small pattern-table model.
module tb_bp_update_scheduler;

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned QL = 2;

  logic          clk, rst, PL_stall, upd_valid, upd_taken, upd_ready;
  logic [IW-1:0] upd_idx, rb_idx, tbl_raddr, tbl_waddr;
  logic          rb_valid, tbl_gnt, tbl_re, tbl_we, init_busy;
  logic [CW-1:0] rb_count, tbl_rdata, tbl_wdata;
  logic [QL:0]   q_count;

  typedef struct {
    logic [IW-1:0] a;
    logic [CW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [CW-1:0] mem [2**IW];

  bp_update_scheduler #(
    .IDX_WIDTH(IW), .CNT_WIDTH(CW), .INIT_VALUE(2'd0), .QDEPTH_LOG2(QL)
  ) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .rb_valid(rb_valid), .rb_idx(rb_idx), .rb_count(rb_count),
    .tbl_gnt(tbl_gnt), .tbl_re(tbl_re), .tbl_raddr(tbl_raddr), .tbl_rdata(tbl_rdata),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .init_busy(init_busy), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern table: read data one cycle after tbl_re, read-before-write
  always @(posedge clk) begin
    if (rst) begin
      tbl_rdata <= '0;
      for (int i = 0; i < 2**IW; i++) mem[i] <= 2'd3;
    end else begin
      if (tbl_re) tbl_rdata <= mem[tbl_raddr];
      if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (tbl_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %0d, expected no write at %0t",
                 tbl_waddr, tbl_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("table_write{addr,data}", 32'({tbl_waddr, tbl_wdata}), 32'({e.a, e.d}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input int a, input int d);
    exp_q.push_back('{a: IW'(a), d: CW'(d)});
  endtask

  task automatic send(input int idx, input logic taken);
    upd_valid = 1'b1;
    upd_idx   = IW'(idx);
    upd_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (init_busy) n++;
      else break;
    end
    check("sweep_cycles", 32'(n), 32'd16);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int found;
    rst = 1'b1; PL_stall = 1'b0; upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
    rb_valid = 1'b0; rb_idx = '0; rb_count = '0; tbl_gnt = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_tbl_we", 32'(tbl_we), 32'd0);
    check("rst_tbl_re", 32'(tbl_re), 32'd0);
    check("rst_upd_ready", 32'(upd_ready), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);

    for (int i = 0; i < 16; i++) expect_wr(i, 0);
    tick();
    rst = 1'b0;
    wait_sweep();
    check("run_upd_ready", 32'(upd_ready), 32'd1);

    // Back-to-back taken updates to one index exercise forwarding and saturation
    tick();
    tbl_gnt = 1'b1;
    expect_wr(5, 1); expect_wr(5, 2); expect_wr(5, 3); expect_wr(5, 3);
    repeat (4) send(5, 1'b1);
    repeat (5) tick();

    expect_wr(2, 0); expect_wr(2, 1); expect_wr(2, 2);
    send(2, 1'b0); send(2, 1'b1); send(2, 1'b1);
    repeat (5) tick();

    // Fill the FIFO with the port withheld, then drain it
    tbl_gnt = 1'b0;
    expect_wr(1, 1); expect_wr(3, 1); expect_wr(4, 0); expect_wr(6, 1);
    send(1, 1'b1); send(3, 1'b1); send(4, 1'b0); send(6, 1'b1);
    @(negedge clk);
    check("full_q_count", 32'(q_count), 32'd4);
    check("full_upd_ready", 32'(upd_ready), 32'd0);
    tick();
    send(7, 1'b1);
    @(negedge clk);
    check("blocked_5th_q_count", 32'(q_count), 32'd4);
    tick();
    tbl_gnt = 1'b1;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (tbl_we) begin found = 1; break; end
    end
    check("drain_start", 32'(found), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("drain_consecutive", 32'(tbl_we), 32'd1);
    end
    @(negedge clk);
    check("drain_end_we", 32'(tbl_we), 32'd0);
    check("drain_q_count", 32'(q_count), 32'd0);

    // Rollback with two queued and one update in the write stage
    tick();
    tbl_gnt = 1'b0;
    send(8, 1'b1); send(10, 1'b1); send(11, 1'b1);
    tbl_gnt = 1'b1;
    tick();
    tbl_gnt = 1'b0; rb_valid = 1'b1; rb_idx = IW'(9); rb_count = 2'd2;
    expect_wr(9, 2);
    @(negedge clk);
    check("rb_pre_q_count", 32'(q_count), 32'd2);
    check("rb_no_read", 32'(tbl_re), 32'd0);
    tick();
    rb_valid = 1'b0;
    @(negedge clk);
    check("rb_post_q_count", 32'(q_count), 32'd0);
    check("rb_post_we", 32'(tbl_we), 32'd0);
    tick();
    tbl_gnt = 1'b1;
    repeat (6) tick();

    // Stall blocks enqueue
    PL_stall = 1'b1; upd_valid = 1'b1; upd_idx = IW'(0); upd_taken = 1'b1;
    tick(); tick();
    upd_valid = 1'b0; PL_stall = 1'b0;
    @(negedge clk);
    check("stall_q_count", 32'(q_count), 32'd0);
    tick();
    repeat (4) tick();

    // Reset while an update sits in the write stage
    tbl_gnt = 1'b0;
    send(12, 1'b1); send(13, 1'b1);
    tbl_gnt = 1'b1;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", 32'(tbl_we), 32'd0);
    for (int i = 0; i < 16; i++) expect_wr(i, 0);
    tick();
    @(negedge clk);
    check("midrst_init_busy", 32'(init_busy), 32'd1);
    check("midrst_q_count", 32'(q_count), 32'd0);
    check("midrst_re", 32'(tbl_re), 32'd0);
    tick();
    rst = 1'b0;
    wait_sweep();
    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
